dsp_uart_tx: RTL and testbench

Output peripheral that sits at the display end of the tiny16 bus. It captures each 16-bit word the controller drives while asserting `dsp_in_en` (the OUT instruction) and queues it in a FIFO. It then transmits each word over an 8N1 serial line as four uppercase hex ASCII characters followed by a line feed. It replaces a raw display latch, so CPU output is readable on a terminal.

---
 rtl/dsp_uart_tx.sv | 181 ++++++++++++++++++
 tb/tb_dsp_uart_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_uart_tx.sv
// dsp_uart_tx: queues 16-bit OUT words and sends each as 4 hex chars + LF on 8N1 tx.
// Ports: clk, rst (async active-low), in/dsp_in_en (write), tx, full, busy, overflow.
module dsp_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        dsp_in_en,
  output logic        tx,
  output logic        full,
  output logic        busy,
  output logic        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      idx_q, idx_d;
  logic [15:0]     word_q, word_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tx_q, tx_d;
  logic            full_q, full_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     mem_q [FIFO_DEPTH];

  logic            tick;
  logic            pop;
  logic            wr_ok;
  logic [3:0]      nib;
  logic [7:0]      char_d;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return {4'h3, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    word_d   = word_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    pop      = 1'b0;
    tick     = (tmr_q == TW'(CLKS_PER_BIT - 1));

    if (state_q == S_IDLE) tmr_d = '0;
    else if (tick)         tmr_d = '0;
    else                   tmr_d = tmr_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (idx_q < 3'd4) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_START;
          end else if (cnt_q != '0) begin
            // chain straight into the next word, no idle gap
            pop     = 1'b1;
            idx_d   = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      word_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // a full FIFO still takes a write when a pop frees a slot on the same edge
    wr_ok = dsp_in_en && ((cnt_q != CW'(FIFO_DEPTH)) || pop);
    if (wr_ok)                 wr_ptr_d = wr_ptr_q + 1'b1;
    if (dsp_in_en && !wr_ok)   ovf_d    = 1'b1;

    unique case ({wr_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    unique case (idx_d)
      3'd0:    nib = word_d[15:12];
      3'd1:    nib = word_d[11:8];
      3'd2:    nib = word_d[7:4];
      default: nib = word_d[3:0];
    endcase
    char_d = (idx_d == 3'd4) ? 8'h0A : hex_char(nib);

    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = char_d[bit_d];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE) || (cnt_d != '0);
    full_d = (cnt_d == CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tx_q     <= 1'b1;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= in;
  end

  assign tx       = tx_q;
  assign full     = full_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_dsp_uart_tx.sv
// tb_dsp_uart_tx: directed stimulus, expected bytes queued in a scoreboard,
// a UART monitor decodes tx and compares each byte against the queue.
module tb_dsp_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = '0;
  logic        en  = 1'b0;
  logic        tx;
  logic        full;
  logic        busy;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb [$];
  logic [7:0] hex_tab [16] = '{
    8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
    8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46
  };

  bit         mon_act;
  int         mon_cnt;
  logic [7:0] mon_byte;

  dsp_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (din),
    .dsp_in_en(en),
    .tx       (tx),
    .full     (full),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    sb.push_back(hex_tab[w[15:12]]);
    sb.push_back(hex_tab[w[11:8]]);
    sb.push_back(hex_tab[w[7:4]]);
    sb.push_back(hex_tab[w[3:0]]);
    sb.push_back(8'h0A);
  endtask

  // drives one write strobe across the next rising edge; en stays high
  task automatic wr(input logic [15:0] w, input bit acc);
    din = w;
    en  = 1'b1;
    if (acc) push_word(w);
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((busy || sb.size() != 0 || mon_act) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", (n < budget), 1);
    check("sb_empty", sb.size(), 0);
  endtask

  // UART monitor: samples each bit mid-period on the falling clock edge
  initial begin
    logic [7:0] exp;
    int k;
    mon_act  = 1'b0;
    mon_cnt  = 0;
    mon_byte = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (tx == 1'b0) begin
          mon_act = 1'b1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % CPB == CPB / 2) begin
          k = mon_cnt / CPB;
          if (k == 0) begin
            check("start_bit", tx, 0);
          end else if (k <= 8) begin
            mon_byte = {tx, mon_byte[7:1]};
          end else begin
            check("stop_bit", tx, 1);
            if (sb.size() == 0) begin
              check("extra_byte", mon_byte, 32'hFFFF_FFFF);
            end else begin
              exp = sb.pop_front();
              check("byte", mon_byte, exp);
            end
            mon_act = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int txbad;
    int busybad;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b1;
    @(negedge clk);

    // single word: start latency and word duration
    wr(16'h1234, 1);
    en = 1'b0;
    check("busy_after_wr", busy, 1);
    check("tx_before_start", tx, 1);
    @(negedge clk);
    check("start_latency", tx, 0);
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("busy_len", n, 200);
    wait_drain(1000);

    // letter digits and leading zeros, back to back
    wr(16'hABCF, 1);
    wr(16'h0009, 1);
    en = 1'b0;
    wait_drain(2000);

    // ten consecutive writes from idle: 0x0009 is dropped
    for (int i = 0; i < 10; i++) begin
      wr(16'(i), (i < 9));
      if (i == 8) begin
        check("ovf_full8", full, 1);
        check("ovf_clear8", overflow, 0);
      end
      if (i == 9) begin
        check("ovf_full9", full, 1);
        check("ovf_set9", overflow, 1);
      end
    end
    en = 1'b0;
    wait_drain(3000);

    // reset clears the sticky flag
    rst = 1'b0;
    @(negedge clk);
    check("ovf_rst", overflow, 0);
    rst = 1'b1;
    @(negedge clk);

    // write on the pop edge while full
    for (int i = 0; i < 9; i++) wr(16'h0100 + 16'(i), 1);
    en = 1'b0;
    check("wop_full_pre", full, 1);
    repeat (192) @(negedge clk);
    check("wop_ovf_pre", overflow, 0);
    wr(16'h01AA, 1);
    check("wop_full", full, 1);
    check("wop_ovf", overflow, 0);
    wr(16'h01BB, 0);
    en = 1'b0;
    check("wop_drop_full", full, 1);
    check("wop_drop_ovf", overflow, 1);
    wait_drain(3000);

    // reset in the middle of character 2
    for (int i = 0; i < 9; i++) wr(16'h5670 + 16'(i), 1);
    en = 1'b0;
    check("mid_full_pre", full, 1);
    repeat (90) @(negedge clk);
    check("mid_in_frame", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_tx", tx, 1);
    check("mid_busy", busy, 0);
    check("mid_full", full, 0);
    check("mid_ovf", overflow, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // no strobe: random bus activity must not start anything
    txbad   = 0;
    busybad = 0;
    for (int i = 0; i < 1000; i++) begin
      din = 16'($urandom);
      en  = 1'b0;
      @(negedge clk);
      if (tx !== 1'b1)   txbad++;
      if (busy !== 1'b0) busybad++;
    end
    check("idle_tx", txbad, 0);
    check("idle_busy", busybad, 0);
    check("idle_mon", mon_act, 0);
    check("final_sb", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
